// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: accepts a framed byte stream
// (16-bit word count, program bytes, XOR checksum) and writes it big-endian.
module imem_loader #(
  parameter int unsigned IMSize    = 1024,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_n;
  logic [15:0] word_count;
  logic [17:0] index;
  logic [7:0]  checksum;

  logic        accept;
  logic        start_ok;
  logic [15:0] wc_next;
  logic [17:0] wc_bytes;
  logic        last_byte;

  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHK);
  assign busy     = in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  // Length is checked on the full 18-bit byte count so 16K+ words cannot wrap
  assign wc_next   = {word_count[15:8], in_data};
  assign wc_bytes  = {wc_next, 2'b00};
  assign last_byte = (18'(index + 18'd1) == {word_count, 2'b00});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LEN_HI;
      S_LEN_HI: if (accept) state_n = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (32'(wc_bytes) > IMSize) state_n = S_ERR;
          else if (wc_next == '0)     state_n = S_CHK;
          else                        state_n = S_DATA;
        end
      end
      S_DATA: if (accept && last_byte) state_n = S_CHK;
      S_CHK: if (accept) state_n = (in_data == checksum) ? S_DONE : S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
      index      <= '0;
      checksum   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) begin
        word_count <= '0;
        index      <= '0;
        checksum   <= '0;
      end
      if (accept) begin
        unique case (state)
          S_LEN_HI: word_count[15:8] <= in_data;
          S_LEN_LO: word_count[7:0]  <= in_data;
          S_DATA: begin
            checksum <= checksum ^ in_data;
            index    <= index + 18'd1;
            wr_en    <= 1'b1;
            wr_addr  <= BASE_ADDR + 32'(index);
            wr_data  <= in_data;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum/length errors,
// backpressure, mid-load reset and restart, with a write-capture monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]  strm[$];
  logic [7:0]  exp_data[$];
  logic [31:0] cap_addr[$];
  logic [7:0]  cap_data[$];

  imem_loader #(.IMSize(1024), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      cap_addr.push_back(wr_addr);
      cap_data.push_back(wr_data);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic stream();
    for (int i = 0; i < strm.size(); i++) begin
      in_valid = 1'b1;
      in_data  = strm[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold} !== 6'b000001) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000001", {in_ready, wr_en, busy, done, error, cpu_hold});
    end
    total++;
    if ({wr_addr, wr_data} !== 40'h0) begin
      bad++;
      $display("FAIL reset_wr got=%h/%h exp=0/0", wr_addr, wr_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_load();
    clear_capture();
    strm     = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    exp_data = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    pulse_start();
    stream();
    total++;
    if (cap_addr.size() != 8) begin
      bad++;
      $display("FAIL good_wcount got=%0d exp=8", cap_addr.size());
    end
    for (int i = 0; i < 8 && i < cap_addr.size(); i++) begin
      total++;
      if (cap_addr[i] !== 32'(i) || cap_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL good_write%0d got=%h/%h exp=%h/%h", i, cap_addr[i], cap_data[i], 32'(i), exp_data[i]);
      end
    end
    total++;
    if ({done, error, cpu_hold, busy, in_ready, wr_en} !== 6'b100000) begin
      bad++;
      $display("FAIL good_status got=%b exp=100000", {done, error, cpu_hold, busy, in_ready, wr_en});
    end
  endtask

  task automatic test_bad_checksum();
    clear_capture();
    strm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0F};
    exp_data = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    pulse_start();
    stream();
    total++;
    if (cap_addr.size() != 8) begin
      bad++;
      $display("FAIL badchk_wcount got=%0d exp=8", cap_addr.size());
    end
    for (int i = 0; i < 8 && i < cap_addr.size(); i++) begin
      total++;
      if (cap_addr[i] !== 32'(i) || cap_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL badchk_write%0d got=%h/%h exp=%h/%h", i, cap_addr[i], cap_data[i], 32'(i), exp_data[i]);
      end
    end
    total++;
    if ({done, error, cpu_hold, busy} !== 4'b0110) begin
      bad++;
      $display("FAIL badchk_status got=%b exp=0110", {done, error, cpu_hold, busy});
    end
  endtask

  task automatic test_oversize();
    clear_capture();
    strm = '{8'h01, 8'h01};
    pulse_start();
    total++;
    if ({busy, error, in_ready} !== 3'b101) begin
      bad++;
      $display("FAIL over_started got=%b exp=101", {busy, error, in_ready});
    end
    stream();
    total++;
    if ({error, done, in_ready, busy, cpu_hold} !== 5'b10001) begin
      bad++;
      $display("FAIL over_status got=%b exp=10001", {error, done, in_ready, busy, cpu_hold});
    end
    repeat (3) @(negedge clk);
    total++;
    if (cap_addr.size() != 0) begin
      bad++;
      $display("FAIL over_writes got=%0d exp=0", cap_addr.size());
    end
  endtask

  task automatic test_zero_len_backpressure();
    clear_capture();
    pulse_start();
    in_valid = 1'b1; in_data = 8'h00; @(negedge clk);
    in_valid = 1'b0; in_data = 8'hFF; @(negedge clk);
    in_valid = 1'b1; in_data = 8'h00; @(negedge clk);
    in_valid = 1'b0; in_data = 8'hFF; @(negedge clk);
    total++;
    if ({done, busy, in_ready} !== 3'b011) begin
      bad++;
      $display("FAIL zero_in_chk got=%b exp=011", {done, busy, in_ready});
    end
    in_valid = 1'b1; in_data = 8'h00; @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({done, error, cpu_hold, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL zero_status got=%b exp=1000", {done, error, cpu_hold, busy});
    end
    total++;
    if (cap_addr.size() != 0) begin
      bad++;
      $display("FAIL zero_writes got=%0d exp=0", cap_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    clear_capture();
    strm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    pulse_start();
    stream();
    // A fifth data byte is presented as reset asserts: its write must never appear
    in_valid = 1'b1; in_data = 8'h20;
    #1 reset = 1'b1;
    #1;
    total++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold} !== 6'b000001 || {wr_addr, wr_data} !== 40'h0) begin
      bad++;
      $display("FAIL midrst_outputs got=%b %h/%h exp=000001 0/0",
               {in_ready, wr_en, busy, done, error, cpu_hold}, wr_addr, wr_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (cap_addr.size() != 4) begin
      bad++;
      $display("FAIL midrst_wcount got=%0d exp=4", cap_addr.size());
    end
    test_good_load();
  endtask

  task automatic test_restart_from_done();
    clear_capture();
    strm     = '{8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    exp_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulse_start();
    total++;
    if ({done, cpu_hold, busy} !== 3'b011) begin
      bad++;
      $display("FAIL restart_status got=%b exp=011", {done, cpu_hold, busy});
    end
    stream();
    total++;
    if (cap_addr.size() != 4) begin
      bad++;
      $display("FAIL restart_wcount got=%0d exp=4", cap_addr.size());
    end
    for (int i = 0; i < 4 && i < cap_addr.size(); i++) begin
      total++;
      if (cap_addr[i] !== 32'(i) || cap_data[i] !== exp_data[i]) begin
        bad++;
        $display("FAIL restart_write%0d got=%h/%h exp=%h/%h", i, cap_addr[i], cap_data[i], 32'(i), exp_data[i]);
      end
    end
    total++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      bad++;
      $display("FAIL restart_done got=%b exp=100", {done, error, cpu_hold});
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_oversize();
    test_zero_len_backpressure();
    test_reset_mid_load();
    test_restart_from_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
